// File: rtl/move_queue.sv
// Move-command FIFO between the SPI parser and the stepping engine.
// Ports: clk/reset, flush, clr_status, wr_* push side, rd_* pop side, count, overflow/underrun.
module move_queue #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       clr_status,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic                       wr_dir,
  input  logic [WORD_W-1:0]          wr_duration,
  input  logic [WORD_W-1:0]          wr_increment,
  input  logic [WORD_W-1:0]          wr_incinc,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic                       rd_dir,
  output logic [WORD_W-1:0]          rd_duration,
  output logic [WORD_W-1:0]          rd_increment,
  output logic [WORD_W-1:0]          rd_incinc,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic              mem_dir [DEPTH];
  logic [WORD_W-1:0] mem_dur [DEPTH];
  logic [WORD_W-1:0] mem_inc [DEPTH];
  logic [WORD_W-1:0] mem_ii  [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] cnt;
  logic          armed;
  logic          ovf;
  logic          und;

  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          ovf_set;
  logic          und_set;

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];

  assign empty = (wr_ptr == rd_ptr);
  // same slot, opposite lap: writer is a full lap ahead
  assign full  = (wr_idx == rd_idx) &&
                 (wr_ptr[AW] != rd_ptr[AW]);

  // flush wins over any transfer in the same cycle
  assign push = wr_valid & ~full & ~flush;
  assign pop  = rd_ready & ~empty & ~flush;

  // status events are judged on the pre-edge state
  assign ovf_set = wr_valid & full;
  assign und_set = rd_ready & empty & armed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      armed  <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      armed  <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        armed  <= 1'b1;
      end
      if (push && !pop)
        cnt <= cnt + PW'(1);
      else if (pop && !push)
        cnt <= cnt - PW'(1);
    end
  end

  // sticky flags; a set in the clear cycle survives
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
      und <= 1'b0;
    end else begin
      if (ovf_set)
        ovf <= 1'b1;
      else if (clr_status)
        ovf <= 1'b0;
      if (und_set)
        und <= 1'b1;
      else if (clr_status)
        und <= 1'b0;
    end
  end

  // payload storage is left unreset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_dir[wr_idx] <= wr_dir;
      mem_dur[wr_idx] <= wr_duration;
      mem_inc[wr_idx] <= wr_increment;
      mem_ii[wr_idx]  <= wr_incinc;
    end
  end

  assign wr_ready = ~full;
  assign rd_valid = ~empty;
  assign count    = cnt;
  assign overflow = ovf;
  assign underrun = und;

  // fall-through head; zeroed while empty
  always_comb begin
    rd_dir       = 1'b0;
    rd_duration  = '0;
    rd_increment = '0;
    rd_incinc    = '0;
    if (!empty) begin
      rd_dir       = mem_dir[rd_idx];
      rd_duration  = mem_dur[rd_idx];
      rd_increment = mem_inc[rd_idx];
      rd_incinc    = mem_ii[rd_idx];
    end
  end

endmodule

// File: tb/tb_move_queue.sv
// Testbench for move_queue: queue-based reference model, per-cycle compare,
// directed scenarios and randomized traffic.
module tb_move_queue;

  localparam int DEPTH  = 4;
  localparam int WORD_W = 64;

  typedef struct {
    logic        dir;
    logic [63:0] dur;
    logic [63:0] inc;
    logic [63:0] ii;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic clr_status = 1'b0;
  logic wr_valid = 1'b0;
  logic wr_ready;
  logic wr_dir = 1'b0;
  logic [63:0] wr_duration = '0;
  logic [63:0] wr_increment = '0;
  logic [63:0] wr_incinc = '0;
  logic rd_valid;
  logic rd_ready = 1'b0;
  logic rd_dir;
  logic [63:0] rd_duration;
  logic [63:0] rd_increment;
  logic [63:0] rd_incinc;
  logic [2:0] count;
  logic overflow;
  logic underrun;

  int n_checks = 0;
  int n_fail = 0;

  rec_t q[$];
  bit m_armed = 0;
  bit m_ovf = 0;
  bit m_und = 0;

  move_queue #(.DEPTH(DEPTH), .WORD_W(WORD_W)) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .clr_status(clr_status),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_dir(wr_dir),
    .wr_duration(wr_duration),
    .wr_increment(wr_increment),
    .wr_incinc(wr_incinc),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .rd_dir(rd_dir),
    .rd_duration(rd_duration),
    .rd_increment(rd_increment),
    .rd_incinc(rd_incinc),
    .count(count),
    .overflow(overflow),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_armed = 0;
    m_ovf = 0;
    m_und = 0;
  endtask

  // reference model: one step per clock edge
  always @(posedge clk) begin
    if (!reset) begin
      bit full;
      bit empty;
      rec_t r;
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      if (clr_status) begin
        m_ovf = 0;
        m_und = 0;
      end
      if (wr_valid && full) m_ovf = 1;
      if (rd_ready && empty && m_armed) m_und = 1;
      if (flush) begin
        q.delete();
        m_armed = 0;
      end else begin
        if (rd_ready && !empty) begin
          void'(q.pop_front());
          m_armed = 1;
        end
        if (wr_valid && !full) begin
          r.dir = wr_dir;
          r.dur = wr_duration;
          r.inc = wr_increment;
          r.ii  = wr_incinc;
          q.push_back(r);
        end
      end
    end
  end

  // compare process: outputs depend only on state
  always @(negedge clk) begin
    if (!reset) begin
      chk("count", 64'(count), 64'(q.size()));
      chk("wr_ready", 64'(wr_ready), 64'(q.size() != DEPTH));
      chk("rd_valid", 64'(rd_valid), 64'(q.size() != 0));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("underrun", 64'(underrun), 64'(m_und));
      if (q.size() != 0) begin
        chk("rd_dir", 64'(rd_dir), 64'(q[0].dir));
        chk("rd_duration", rd_duration, q[0].dur);
        chk("rd_increment", rd_increment, q[0].inc);
        chk("rd_incinc", rd_incinc, q[0].ii);
      end else begin
        chk("rd_dir_zero", 64'(rd_dir), 64'd0);
        chk("rd_duration_zero", rd_duration, 64'd0);
        chk("rd_increment_zero", rd_increment, 64'd0);
        chk("rd_incinc_zero", rd_incinc, 64'd0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_valid = 0;
    rd_ready = 0;
    flush = 0;
    clr_status = 0;
  endtask

  task automatic set_wr(input logic d, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] c);
    wr_dir = d;
    wr_duration = a;
    wr_increment = b;
    wr_incinc = c;
  endtask

  task automatic push_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1;
      set_wr(i[0], 64'(base + i), 64'(base * 7 + i), 64'(base + 3 * i));
      cyc();
    end
    wr_valid = 0;
  endtask

  initial begin
    model_reset();
    #3;
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_flags", 64'({overflow, underrun}), 64'd0);
    chk("rst_rd_dur", rd_duration, 64'd0);
    @(posedge clk);
    #1;
    reset = 0;

    // starving before any move is not an underrun
    rd_ready = 1;
    cyc();
    rd_ready = 0;
    chk("t4_no_underrun", 64'(underrun), 64'd0);

    // single record round trip
    wr_valid = 1;
    set_wr(1'b1, 64'h4FFFFF, 64'd100000000000, 64'd1000000000);
    cyc();
    wr_valid = 0;
    chk("t1_rd_valid", 64'(rd_valid), 64'd1);
    chk("t1_dir", 64'(rd_dir), 64'd1);
    chk("t1_dur", rd_duration, 64'h4FFFFF);
    chk("t1_inc", rd_increment, 64'd100000000000);
    chk("t1_ii", rd_incinc, 64'd1000000000);
    chk("t1_count", 64'(count), 64'd1);
    rd_ready = 1;
    cyc();
    rd_ready = 0;
    chk("t1_empty", 64'(rd_valid), 64'd0);

    // starving after a move is an underrun
    rd_ready = 1;
    cyc();
    rd_ready = 0;
    chk("t4_underrun", 64'(underrun), 64'd1);
    clr_status = 1;
    cyc();
    clr_status = 0;
    chk("t4_cleared", 64'(underrun), 64'd0);

    // overflow: 5 pushes into depth 4
    for (int i = 1; i <= 5; i++) begin
      wr_valid = 1;
      set_wr(1'b0, 64'(16 * i), 64'(i), 64'(i));
      cyc();
      if (i == 4) chk("t2_full", 64'(wr_ready), 64'd0);
    end
    wr_valid = 0;
    chk("t2_overflow", 64'(overflow), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("t2_order", rd_duration, 64'(16 * i));
      rd_ready = 1;
      cyc();
    end
    rd_ready = 0;
    chk("t2_drained", 64'(count), 64'd0);

    // flush beats push and pop; flags untouched
    push_n(3, 200);
    chk("t5_count3", 64'(count), 64'd3);
    flush = 1;
    wr_valid = 1;
    rd_ready = 1;
    cyc();
    idle();
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_rd_valid", 64'(rd_valid), 64'd0);
    chk("t5_overflow", 64'(overflow), 64'd1);
    clr_status = 1;
    cyc();
    clr_status = 0;

    // steady-state push+pop across pointer wrap
    push_n(2, 300);
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1;
      rd_ready = 1;
      set_wr(1'b1, 64'(400 + i), 64'(i), 64'(i));
      cyc();
      chk("t3_count", 64'(count), 64'd2);
    end
    idle();
    chk("t3_head", rd_duration, 64'd408);

    // async reset between edges
    @(posedge clk);
    #3;
    reset = 1;
    model_reset();
    #1;
    chk("t6_rd_valid", 64'(rd_valid), 64'd0);
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_rd_dur", rd_duration, 64'd0);
    @(posedge clk);
    #1;
    reset = 0;
    wr_valid = 1;
    set_wr(1'b0, 64'h1234, 64'h5, 64'h6);
    cyc();
    wr_valid = 0;
    chk("t6_push", rd_duration, 64'h1234);
    chk("t6_count1", 64'(count), 64'd1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      flush = ($urandom_range(0, 99) == 0);
      clr_status = ($urandom_range(0, 19) == 0);
      if (flush) begin
        wr_valid = 0;
        rd_ready = 0;
      end else begin
        wr_valid = ($urandom_range(0, 99) < 55);
        rd_ready = ($urandom_range(0, 99) < 45);
      end
      set_wr(1'($urandom), {$urandom, $urandom},
             {$urandom, $urandom}, {$urandom, $urandom});
      cyc();
    end
    idle();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
